uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: the downstream counterpart of the UART transmitter. It accepts 8N1-style frames on `uart_in` (start bit, DATA_WIDTH data bits LSB first, one stop bit) and returns parallel words through a valid/ready handshake. It flags framing errors and overruns. It sits between the board RX pin and the consumer logic, typically a FIFO or command decoder.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `BAUD_RATE`, 115200: line bit rate.
- `CLK_FREQ`, 100_000_000: `clk` frequency in Hz. Legal only when CLK_FREQ/BAUD_RATE ≥ 8.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `uart_in`  in  1  serial line; asynchronous to `clk`; idles high.
- `data`  out  DATA_WIDTH  received word; stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed word.
- `ready`  in  1  consumer accepts `data` when `valid`&&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good frame completed while `valid`=1 and not accepted that cycle.

## Operation
- Constants:
  - PULSE = CLK_FREQ/BAUD_RATE (integer division).
  - HALF = PULSE/2.
  - `clk_cnt` is 32-bit.
  - `bit_cnt` is $clog2(DATA_WIDTH) bits wide.
- Reset values:
  - Synchronizer flops and `rx_prev` are 1.
  - State is IDLE; `data`, `valid`, `frame_err`, `overrun`, `clk_cnt`, `bit_cnt` and the shift register are 0.
- Input path: 2-flop synchronizer produces `rx_s`. `rx_prev` is `rx_s` delayed one cycle.
- IDLE:
  - When `rx_prev`=1 and `rx_s`=0 (falling edge): `clk_cnt`←HALF-1, go to START.
  - A line that is held low never re-triggers; it must return high first.
- START:
  - Decrement `clk_cnt` until it reaches 0, then sample.
  - Sample 0: `clk_cnt`←PULSE-1, `bit_cnt`←0, go to DATA.
  - Sample 1: glitch, return to IDLE with no outputs.
- DATA:
  - At `clk_cnt`=0, shift right with the sample entering the MSB (LSB-first reconstruction) and reload PULSE-1.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP: at `clk_cnt`=0, sample, then return to IDLE.
  - Sample 1 and (`valid`=0 or `ready`=1): `data`←shift register, `valid`←1.
  - Sample 1 and `valid`=1 and `ready`=0: `overrun` pulses; `data` keeps the old word and the new word is dropped.
  - Sample 0: `frame_err` pulses; word discarded, `valid` unchanged.
- Handshake:
  - `valid` falls on the edge where `valid`&&`ready`.
  - A frame completing on the same edge as acceptance loads the new word, and `valid` stays 1.
- Unused state encodings go to IDLE.
- Reset mid-frame aborts immediately; no partial word or pulse appears.

## Timing
- Let edge k be the first `clk` edge that captures `uart_in`=0 for the start bit. IDLE detects the edge at k+2.
- Start-bit sample: edge k+2+HALF.
- Data bit i sample: edge k+2+HALF+(i+1)·PULSE.
- Stop-bit sample: edge E = k+2+HALF+(DATA_WIDTH+1)·PULSE.
- `valid`, `frame_err` and `overrun` are registered and become visible after edge E.
- Pulses last exactly one cycle.
- Back-to-back frames are accepted: IDLE re-arms at E+1, i.e. half a bit before the nominal stop-bit end.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit (start, data, stop) is decided by a 2-of-3 majority of `rx_s` at `clk_cnt`=2, 1 and 0. The decision edge is unchanged.
- `UART_RX_MAJORITY_EN` undefined: single sample of `rx_s` at `clk_cnt`=0.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}, logic [1:0].
  - Functions `pulse_width(clk_freq, baud)` and `half_pulse_width(...)`. The transmitter shares these.
- Sub-module `uart_sync`: parameterised N-flop synchronizer (default 2) with reset value 1. Async active-low reset.

## Test plan
All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (PULSE=10, HALF=5).
- Frame 0xA5, `ready`=1 → `data`=0xA5; `valid` high for exactly one cycle, after edge k+2+5+90=k+97; `frame_err`=`overrun`=0.
- Stop bit driven 0 on frame 0x3C → `frame_err` pulses once after edge k+97; `valid` stays 0. The next good frame 0x11 is received normally once the line returns high.
- 3-cycle low glitch from idle → START sample reads 1, return to IDLE, no `valid`/`frame_err`.
- `ready`=0, frames 0x01 then 0x02 back-to-back → `valid`=1 with `data`=0x01 and one `overrun` pulse at the second stop sample. Raising `ready` then drops `valid` and `data` stays 0x01.
- `rstn` asserted low in the middle of data bit 4, released, then frame 0x5A → no output from the aborted frame; 0x5A is received correctly.
- With `UART_RX_MAJORITY_EN`: a 1-cycle inverted spike at the mid-bit of bit 3 of frame 0xFF → `data`=0xFF. Without the macro, the spike on the decision edge → `data`=0xF7.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and bit-timing helpers
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int pulse_width(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_pulse_width(input int clk_freq, input int baud);
    return pulse_width(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchronizer, resets to 1 (idle line level)
// N must be at least 2.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART receiver with valid/ready output, framing and overrun pulses
// Optional UART_RX_MAJORITY_EN: decide each bit by 2-of-3 vote over the last three cycles.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  uart_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF  = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [31:0]      PULSE_RELOAD = 32'(PULSE - 1);
  localparam logic [31:0]      HALF_RELOAD  = 32'(HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_WIDTH - 1);

  logic                  rx_s;
  logic                  rx_prev_q;
  logic                  bit_val;
  rx_state_t             state_q, state_d;
  logic [31:0]           clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  uart_sync #(.N(2)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (uart_in),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // rx_prev_q is the sample at clk_cnt=1, rx_prev2_q the one at clk_cnt=2
  logic rx_prev2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_prev2_q <= 1'b1;
    end else begin
      rx_prev2_q <= rx_prev_q;
    end
  end

  assign bit_val = (rx_s & rx_prev_q) | (rx_s & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          clk_cnt_d = HALF_RELOAD;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt_q != 32'd0) begin
          clk_cnt_d = clk_cnt_q - 32'd1;
        end else if (!bit_val) begin
          clk_cnt_d = PULSE_RELOAD;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (clk_cnt_q != 32'd0) begin
          clk_cnt_d = clk_cnt_q - 32'd1;
        end else begin
          shift_d   = DATA_WIDTH'({bit_val, shift_q} >> 1);
          clk_cnt_d = PULSE_RELOAD;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (clk_cnt_q != 32'd0) begin
          clk_cnt_d = clk_cnt_q - 32'd1;
        end else begin
          state_d = IDLE;
          if (bit_val) begin
            // A word still waiting for the consumer wins; the new one is dropped
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized bench for uart_rx against a line-level frame model
// Build with UART_RX_MAJORITY_EN defined to check the voting variant.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int P        = 10;
  localparam int H        = 5;
  localparam int DW       = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          uart_in = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  uart_rx #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (BAUD),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .uart_in   (uart_in),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Per-edge stimulus: element t is what edge t sees on each input
  bit line_q[$];
  bit rst_q[$];
  bit rdy_q[$];

  logic [DW-1:0] obs_data[];
  bit            obs_valid[];
  bit            obs_ferr[];
  bit            obs_ovr[];
  logic [DW-1:0] exp_data[];
  bit            exp_valid[];
  bit            exp_ferr[];
  bit            exp_ovr[];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit b, input int n);
    repeat (n) begin
      line_q.push_back(b);
      rst_q.push_back(1'b1);
    end
  endtask

  task automatic idle(input int n);
    put(1'b1, n);
  endtask

  // Start bit begins at line index k; spike>=0 inverts the mid-point of that data bit
  task automatic frame(input logic [DW-1:0] d, input bit stop, input int spike, output int k);
    k = line_q.size();
    put(1'b0, P);
    for (int i = 0; i < DW; i++) put(d[i], P);
    put(stop, P);
    if (spike >= 0) line_q[k + H + (spike + 1) * P] = ~line_q[k + H + (spike + 1) * P];
  endtask

  // Bit decision seen at edge t: synchronizer makes rx_s at edge t equal line[t-2]
  function automatic bit sample(input int t);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(line_q[t-4]) + int'(line_q[t-3]) + int'(line_q[t-2]);
    return ones >= 2;
`else
    return line_q[t-2];
`endif
  endfunction

  int k_a5, k_bad, k_ov, k_rst, k_5a, k_spk, k_tmp, rst_at, n;

  initial begin
    idle(20);
    frame(8'hA5, 1'b1, -1, k_a5);
    idle(30);
    frame(8'h3C, 1'b0, -1, k_bad);
    idle(30);
    frame(8'h11, 1'b1, -1, k_tmp);
    idle(20);
    put(1'b0, 3);
    idle(30);
    frame(8'h01, 1'b1, -1, k_ov);
    frame(8'h02, 1'b1, -1, k_tmp);
    idle(60);
    // Aborted frame: line released high in the middle of data bit 4, reset applied there
    k_rst = line_q.size();
    put(1'b0, P);
    for (int i = 0; i < 4; i++) put(1'(8'hC3 >> i), P);
    put(1'b0, H);
    rst_at = line_q.size();
    idle(40);
    for (int i = 0; i < 5; i++) rst_q[rst_at + i] = 1'b0;
    frame(8'h5A, 1'b1, -1, k_5a);
    idle(30);
    frame(8'hFF, 1'b1, 3, k_spk);
    for (int r = 0; r < 25; r++) begin
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) begin
        put(1'b0, $urandom_range(1, 4));
        idle(10);
      end
      frame(8'($urandom), $urandom_range(0, 7) != 0, -1, k_tmp);
    end
    idle(150);
    n = line_q.size();
    for (int t = 0; t < 4; t++) rst_q[t] = 1'b0;

    for (int t = 0; t < n; t++) rdy_q.push_back($urandom_range(0, 3) != 0);
    for (int t = k_a5; t < k_a5 + 120; t++) rdy_q[t] = 1'b1;
    for (int t = k_ov; t < k_ov + 220; t++) rdy_q[t] = 1'b0;
    for (int t = k_ov + 220; t < k_ov + 240; t++) rdy_q[t] = 1'b1;
    for (int t = k_spk; t < k_spk + 120; t++) rdy_q[t] = 1'b1;

    // Reference: frames found on the line, decoded at the spec's sample edges
    exp_data = new[n]; exp_valid = new[n]; exp_ferr = new[n]; exp_ovr = new[n];
    begin
      bit            busy = 1'b0;
      bit            v = 1'b0;
      bit            v_old;
      logic [DW-1:0] d = '0;
      logic [DW-1:0] w = '0;
      int            armed = 0;
      int            es = 0;
      int            ee = 0;
      for (int t = 0; t < n; t++) begin
        exp_ferr[t] = 1'b0;
        exp_ovr[t]  = 1'b0;
        if (!rst_q[t]) begin
          v = 1'b0; d = '0; busy = 1'b0; armed = t + 3;
        end else begin
          v_old = v;
          if (v && rdy_q[t]) v = 1'b0;
          if (busy && t == es && sample(t)) begin
            busy = 1'b0; armed = t + 1;
          end else if (busy && t == ee) begin
            if (sample(t)) begin
              if (!v_old || rdy_q[t]) begin d = w; v = 1'b1; end
              else exp_ovr[t] = 1'b1;
            end else begin
              exp_ferr[t] = 1'b1;
            end
            busy = 1'b0; armed = t + 1;
          end else if (!busy && t >= armed && t >= 3 && line_q[t-3] && !line_q[t-2]) begin
            busy = 1'b1;
            es = t + H;
            ee = t + H + (DW + 1) * P;
            for (int i = 0; i < DW; i++) w[i] = sample(t + H + (i + 1) * P);
          end
        end
        exp_data[t]  = d;
        exp_valid[t] = v;
      end
    end

    obs_data = new[n]; obs_valid = new[n]; obs_ferr = new[n]; obs_ovr = new[n];
    rstn = rst_q[0]; uart_in = line_q[0]; ready = rdy_q[0];
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      obs_data[t] = data; obs_valid[t] = valid; obs_ferr[t] = frame_err; obs_ovr[t] = overrun;
      if (t + 1 < n) begin
        rstn = rst_q[t+1]; uart_in = line_q[t+1]; ready = rdy_q[t+1];
      end
    end

    for (int t = 0; t < n; t++) begin
      check($sformatf("valid@%0d", t), 32'(obs_valid[t]), 32'(exp_valid[t]));
      check($sformatf("data@%0d", t), 32'(obs_data[t]), 32'(exp_data[t]));
      check($sformatf("frame_err@%0d", t), 32'(obs_ferr[t]), 32'(exp_ferr[t]));
      check($sformatf("overrun@%0d", t), 32'(obs_ovr[t]), 32'(exp_ovr[t]));
    end

    check("a5_valid_before", 32'(obs_valid[k_a5 + 96]), 32'd0);
    check("a5_valid", 32'(obs_valid[k_a5 + 97]), 32'd1);
    check("a5_data", 32'(obs_data[k_a5 + 97]), 32'hA5);
    check("a5_valid_one_cycle", 32'(obs_valid[k_a5 + 98]), 32'd0);
    check("bad_stop_ferr", 32'(obs_ferr[k_bad + 97]), 32'd1);
    check("bad_stop_ferr_one_cycle", 32'(obs_ferr[k_bad + 98]), 32'd0);
    check("bad_stop_valid", 32'(obs_valid[k_bad + 97]), 32'd0);
    check("ovr_first_data", 32'(obs_data[k_ov + 97]), 32'h01);
    check("ovr_pulse", 32'(obs_ovr[k_ov + 197]), 32'd1);
    check("ovr_data_kept", 32'(obs_data[k_ov + 197]), 32'h01);
    check("ovr_valid_dropped", 32'(obs_valid[k_ov + 230]), 32'd0);
    check("ovr_data_after", 32'(obs_data[k_ov + 230]), 32'h01);
    check("after_reset_data", 32'(obs_data[k_5a + 97]), 32'h5A);
    check("after_reset_valid", 32'(obs_valid[k_5a + 97]), 32'd1);
`ifdef UART_RX_MAJORITY_EN
    check("spike_data", 32'(obs_data[k_spk + 97]), 32'hFF);
`else
    check("spike_data", 32'(obs_data[k_spk + 97]), 32'hF7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
